demux_1x8_deser: RTL and testbench

- Serial-to-parallel demultiplexer: the receive end of the 8x1 mux selection path.
- Takes one bit per accepted cycle and steers it into lane S of an 8-bit word, using an internal 3-bit slot counter.
- After 8 bits, presents the assembled word on O with a valid/ready handshake.
- Lane mapping mirrors the mux: the bit accepted in slot k lands in O[k], which is the bit the mux drives onto Y when S=k.

---
 rtl/demux_1x8_deser_if.sv | 27 ++
 rtl/demux_1x8_deser.sv | 92 +++++++++
 tb/tb_demux_1x8_deser.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/demux_1x8_deser_if.sv
// Bundle of signals between the serial source, the demux and the word consumer.
// The slave modport is the demux's view of the bundle. The master modport is the
// view of whoever drives the serial stream and consumes the word.
interface demux_1x8_deser_if #(
  parameter int LANES = 8,
  parameter int SEL_W = 3
);
  logic             D;
  logic             D_valid;
  logic             D_ready;
  logic             frame_start;
  logic [LANES-1:0] O;
  logic             O_valid;
  logic             O_ready;
  logic [SEL_W-1:0] S;
  logic             frame_err;

  modport slave (
    input  D, D_valid, frame_start, O_ready,
    output D_ready, O, O_valid, S, frame_err
  );

  modport master (
    output D, D_valid, frame_start, O_ready,
    input  D_ready, O, O_valid, S, frame_err
  );
endinterface

// File: rtl/demux_1x8_deser.sv
// Serial-to-parallel demux, the receive end of the 8:1 mux selection path.
// Each accepted bit is steered into the lane given by the slot counter S.
// After eight bits, the assembled word is presented on O with a valid/ready
// handshake. frame_start resynchronises the slot counter to slot 0.
module demux_1x8_deser #(
  parameter int LANES     = 8,
  parameter int SEL_W     = 3,
  parameter int LSB_FIRST = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  demux_1x8_deser_if.slave       bus
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

  logic [SEL_W-1:0] s_q, s_d;
  logic [LANES-1:0] col_q, col_d;
  logic [LANES-1:0] o_q, o_d;
  logic             ov_q, ov_d;
  logic             ferr_q, ferr_d;
  logic             d_ready;
  logic             accept;

  // Slot-to-lane mapping. It mirrors the mux, or reverses it for MSB-first links.
  function automatic logic [SEL_W-1:0] lane_of(input logic [SEL_W-1:0] slot);
    if (LSB_FIRST != 0) return slot;
    else                return LAST - slot;
  endfunction

  // Only the word-completing bit can stall, because that bit needs O to be free.
  always_comb begin
    d_ready = !((s_q == LAST) && ov_q && !bus.O_ready);
  end

  assign accept = bus.D_valid && d_ready;

  // Next state. frame_start has priority over word completion. The output
  // handshake drains O_valid unless a new word loads at the same edge.
  always_comb begin
    s_d    = s_q;
    col_d  = col_q;
    o_d    = o_q;
    ov_d   = ov_q;
    ferr_d = 1'b0;
    if (ov_q && bus.O_ready) ov_d = 1'b0;
    if (bus.frame_start) begin
      ferr_d = (s_q != '0);
      col_d  = '0;
      s_d    = '0;
      if (accept) begin
        col_d[lane_of(SEL_W'(0))] = bus.D;
        s_d                       = SEL_W'(1);
      end
    end else if (accept) begin
      if (s_q == LAST) begin
        o_d                = col_q;
        o_d[lane_of(LAST)] = bus.D;
        ov_d               = 1'b1;
        col_d              = '0;
        s_d                = '0;
      end else begin
        col_d[lane_of(s_q)] = bus.D;
        s_d                 = s_q + SEL_W'(1);
      end
    end
  end

  // State registers. Reset clears the partial word and any presented word.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= '0;
      col_q  <= '0;
      o_q    <= '0;
      ov_q   <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      col_q  <= col_d;
      o_q    <= o_d;
      ov_q   <= ov_d;
      ferr_q <= ferr_d;
    end
  end

  assign bus.D_ready   = d_ready;
  assign bus.O         = o_q;
  assign bus.O_valid   = ov_q;
  assign bus.S         = s_q;
  assign bus.frame_err = ferr_q;

endmodule

// File: tb/tb_demux_1x8_deser.sv
// Bench for demux_1x8_deser. It runs an LSB-first and an MSB-first instance
// side by side on the same stimulus. A word-level model checks every cycle, and
// directed literal expectations pin the model at key points.
module tb_demux_1x8_deser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_1x8_deser_if ifa ();
  demux_1x8_deser_if ifb ();

  demux_1x8_deser #(.LANES(8), .SEL_W(3), .LSB_FIRST(1)) dut_a (
    .clk (clk), .rst (rst), .bus (ifa)
  );
  demux_1x8_deser #(.LANES(8), .SEL_W(3), .LSB_FIRST(0)) dut_b (
    .clk (clk), .rst (rst), .bus (ifb)
  );

  assign ifb.D           = ifa.D;
  assign ifb.D_valid     = ifa.D_valid;
  assign ifb.frame_start = ifa.frame_start;
  assign ifb.O_ready     = ifa.O_ready;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model. Bits are kept in arrival order (bit k = slot k), and the
  // lane mapping is applied only when the word is complete.
  int         m_cnt;
  logic [7:0] m_bits;
  logic [7:0] m_oa, m_ob;
  logic       m_ov, m_ferr;
  logic       m_ready, m_acc;

  function automatic logic [7:0] assemble(input logic [7:0] bits, input bit lsb_first);
    logic [7:0] w;
    for (int k = 0; k < 8; k++) w[lsb_first ? k : 7 - k] = bits[k];
    return w;
  endfunction

  assign m_ready = !((m_cnt == 7) && m_ov && !ifa.O_ready);
  assign m_acc   = ifa.D_valid && m_ready;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt  <= 0;
      m_bits <= 8'h00;
      m_oa   <= 8'h00;
      m_ob   <= 8'h00;
      m_ov   <= 1'b0;
      m_ferr <= 1'b0;
    end else begin
      m_ferr <= ifa.frame_start && (m_cnt != 0);
      if (m_ov && ifa.O_ready) m_ov <= 1'b0;
      if (ifa.frame_start) begin
        m_cnt  <= m_acc ? 1 : 0;
        m_bits <= m_acc ? {7'b0, ifa.D} : 8'h00;
      end else if (m_acc) begin
        if (m_cnt == 7) begin
          m_oa   <= assemble({ifa.D, m_bits[6:0]}, 1'b1);
          m_ob   <= assemble({ifa.D, m_bits[6:0]}, 1'b0);
          m_ov   <= 1'b1;
          m_bits <= 8'h00;
          m_cnt  <= 0;
        end else begin
          m_bits[m_cnt] <= ifa.D;
          m_cnt         <= m_cnt + 1;
        end
      end
    end
  end

  // Per-cycle comparison, sampled mid-period while inputs and outputs are stable.
  always @(negedge clk) begin
    if (chk_en) begin
      check("a_O",         ifa.O,         m_oa);
      check("a_O_valid",   ifa.O_valid,   m_ov);
      check("a_S",         ifa.S,         m_cnt[2:0]);
      check("a_frame_err", ifa.frame_err, m_ferr);
      check("a_D_ready",   ifa.D_ready,   m_ready);
      check("b_O",         ifb.O,         m_ob);
      check("b_O_valid",   ifb.O_valid,   m_ov);
      check("b_S",         ifb.S,         m_cnt[2:0]);
    end
  end

  task automatic step(input logic d, input logic dv, input logic fs, input logic ordy, input logic r);
    ifa.D           = d;
    ifa.D_valid     = dv;
    ifa.frame_start = fs;
    ifa.O_ready     = ordy;
    rst             = r;
    @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input logic [7:0] w, input int n, input logic ordy);
    for (int k = 0; k < n; k++) step(w[k], 1'b1, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    ifa.D = 1'b0; ifa.D_valid = 1'b0; ifa.frame_start = 1'b0; ifa.O_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #2;
    chk_en = 1'b1;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("rst_O", ifa.O, 8'h00);
    check("rst_O_valid", ifa.O_valid, 1'b0);
    check("rst_S", ifa.S, 3'd0);
    check("rst_D_ready", ifa.D_ready, 1'b1);

    // Basic word: slots 0..7 carry 0,1,0,0,1,0,1,1.
    send_bits(8'b1101_0010, 8, 1'b1);
    check("t1_O", ifa.O, 8'hD2);
    check("t1_O_valid", ifa.O_valid, 1'b1);
    check("t1_S_wrap", ifa.S, 3'd0);
    check("t1_msb_first_O", ifb.O, 8'h4B);

    // Backpressure: 0x5A while D2 is held with O_ready low.
    send_bits(8'h5A, 7, 1'b0);
    check("t2_S7", ifa.S, 3'd7);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t2_stall_ready", ifa.D_ready, 1'b0);
    check("t2_hold_O", ifa.O, 8'hD2);
    check("t2_hold_S", ifa.S, 3'd7);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t2_O", ifa.O, 8'h5A);
    check("t2_O_valid", ifa.O_valid, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("t2_drained", ifa.O_valid, 1'b0);
    check("t2_O_kept", ifa.O, 8'h5A);

    // Back-to-back words, with no bubble.
    send_bits(8'h01, 8, 1'b1);
    check("t3_w0", ifa.O, 8'h01);
    check("t3_ready", ifa.D_ready, 1'b1);
    send_bits(8'hFF, 8, 1'b1);
    check("t3_w1", ifa.O, 8'hFF);
    check("t3_w1_valid", ifa.O_valid, 1'b1);
    send_bits(8'h80, 8, 1'b1);
    check("t3_w2", ifa.O, 8'h80);
    check("t3_w2_msb_first", ifb.O, 8'h01);

    // Resync after three bits. frame_start arrives with D=1.
    send_bits(8'b0000_0101, 3, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t4_ferr", ifa.frame_err, 1'b1);
    check("t4_S1", ifa.S, 3'd1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("t4_ferr_once", ifa.frame_err, 1'b0);
    send_bits(8'h00, 6, 1'b1);
    check("t4_O", ifa.O, 8'h01);
    check("t4_O_valid", ifa.O_valid, 1'b1);

    // Reset mid-word at S=5.
    send_bits(8'hFF, 5, 1'b1);
    check("t5_S5", ifa.S, 3'd5);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    check("t5_O", ifa.O, 8'h00);
    check("t5_O_valid", ifa.O_valid, 1'b0);
    check("t5_S", ifa.S, 3'd0);
    check("t5_D_ready", ifa.D_ready, 1'b1);

    // Reset while a word is held.
    send_bits(8'hA5, 8, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("t5_held_O", ifa.O, 8'hA5);
    check("t5_held_valid", ifa.O_valid, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("t5b_O", ifa.O, 8'h00);
    check("t5b_O_valid", ifa.O_valid, 1'b0);
    check("t5b_S", ifa.S, 3'd0);
    check("t5b_D_ready", ifa.D_ready, 1'b1);

    // frame_start on the completing bit wins: no word is produced.
    send_bits(8'h7F, 7, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check("t6_no_word", ifa.O_valid, 1'b0);
    check("t6_ferr", ifa.frame_err, 1'b1);
    check("t6_S1", ifa.S, 3'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_idle_fs_S", ifa.S, 3'd0);
    check("t6_idle_fs_ferr", ifa.frame_err, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check("t6_fs_at_0", ifa.frame_err, 1'b0);

    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
